inorder_queue_dispatcher: RTL and testbench

// - Consumer side of the in-order instruction queue: pops entries via the queue's read-enable/empty handshake,

---
 rtl/inorder_queue_dispatcher.sv | 146 ++++++++++++++
 tb/tb_inorder_queue_dispatcher.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inorder_queue_dispatcher.sv
// rtl/inorder_queue_dispatcher.sv - pops the in-order queue, holds one entry, dispatches it to a credited RS.
// Optional perf counters are built when DISPATCH_STATS_EN is defined.
module inorder_queue_dispatcher #(
  parameter int funcUnitCodeSize = 3,
  parameter int numRS            = 4,
  parameter int rsDepthBits      = 3,
  parameter int payloadWidth     = 305
) (
  input  logic                        clock_i,
  input  logic                        reset_i,
  input  logic                        qEmpty_i,
  input  logic [funcUnitCodeSize-1:0] qFuncUnitType_i,
  input  logic [payloadWidth-1:0]     qPayload_i,
  output logic                        qReadEnable_o,
  input  logic                        flush_i,
  input  logic [numRS-1:0]            creditReturn_i,
  output logic [numRS-1:0]            dispValid_o,
  output logic [payloadWidth-1:0]     dispPayload_o,
  output logic                        illegalFU_o,
  output logic [31:0]                 stallCycles_o,
  output logic [31:0]                 dispatchCount_o
);

  localparam int CW = rsDepthBits + 1;
  localparam logic [CW-1:0] CREDIT_MAX = {1'b1, {rsDepthBits{1'b0}}};

  typedef enum logic [1:0] {IDLE, FETCH, WAIT, HOLD} state_t;

  state_t                      state, state_n;
  logic [CW-1:0]               credit [numRS];
  logic [funcUnitCodeSize-1:0] hold_fu;
  logic [payloadWidth-1:0]     hold_payload;
  logic [numRS-1:0]            hit;
  logic [CW-1:0]               sel_credit;
  logic                        legal;
  logic                        re_n;
  logic                        ill_n;
  logic                        latch;
  logic [numRS-1:0]            disp_n;

  // One-hot decode of the held code; no hit means the code names no RS.
  always_comb begin
    hit        = '0;
    sel_credit = '0;
    for (int k = 0; k < numRS; k++) begin
      hit[k] = (hold_fu == funcUnitCodeSize'(k));
      if (hit[k]) sel_credit = credit[k];
    end
    legal = |hit;
  end

  always_comb begin
    state_n = state;
    re_n    = 1'b0;
    ill_n   = 1'b0;
    latch   = 1'b0;
    disp_n  = '0;
    if (flush_i) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (!qEmpty_i) begin
            re_n    = 1'b1;
            state_n = FETCH;
          end
        end
        FETCH: state_n = WAIT;
        // Queue output is valid the cycle after the strobe.
        WAIT: begin
          latch   = 1'b1;
          state_n = HOLD;
        end
        HOLD: begin
          if (!legal) begin
            ill_n   = 1'b1;
            state_n = IDLE;
          end else if (sel_credit != '0) begin
            disp_n  = hit;
            state_n = IDLE;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state         <= IDLE;
      qReadEnable_o <= 1'b0;
      dispValid_o   <= '0;
      dispPayload_o <= '0;
      illegalFU_o   <= 1'b0;
      hold_fu       <= '0;
      hold_payload  <= '0;
    end else begin
      state         <= state_n;
      qReadEnable_o <= re_n;
      dispValid_o   <= disp_n;
      illegalFU_o   <= ill_n;
      if (|disp_n) dispPayload_o <= hold_payload;
      if (latch) begin
        hold_fu      <= qFuncUnitType_i;
        hold_payload <= qPayload_i;
      end else if (state_n != HOLD) begin
        hold_fu      <= '0;
        hold_payload <= '0;
      end
    end
  end

  // Simultaneous dispatch and return cancel; returns saturate at full capacity.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      for (int k = 0; k < numRS; k++) credit[k] <= CREDIT_MAX;
    end else begin
      for (int k = 0; k < numRS; k++) begin
        if (disp_n[k] && !creditReturn_i[k]) begin
          credit[k] <= credit[k] - 1'b1;
        end else if (creditReturn_i[k] && !disp_n[k] && credit[k] != CREDIT_MAX) begin
          credit[k] <= credit[k] + 1'b1;
        end
      end
    end
  end

`ifdef DISPATCH_STATS_EN
  logic stall;
  assign stall = (state == HOLD) && legal && (sel_credit == '0);

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      stallCycles_o   <= '0;
      dispatchCount_o <= '0;
    end else begin
      if (stall) stallCycles_o <= stallCycles_o + 32'd1;
      if (|disp_n) dispatchCount_o <= dispatchCount_o + 32'd1;
    end
  end
`else
  assign stallCycles_o   = 32'd0;
  assign dispatchCount_o = 32'd0;
`endif

endmodule

// File: tb/tb_inorder_queue_dispatcher.sv
// tb/tb_inorder_queue_dispatcher.sv - directed bench for inorder_queue_dispatcher with a registered queue model.
module tb_inorder_queue_dispatcher;
  localparam int FCS = 3;
  localparam int NRS = 4;
  localparam int PW  = 305;

  logic           clock_i = 1'b0;
  logic           reset_i = 1'b1;
  logic           qEmpty_i;
  logic [FCS-1:0] qFuncUnitType_i = '0;
  logic [PW-1:0]  qPayload_i = '0;
  logic           qReadEnable_o;
  logic           flush_i = 1'b0;
  logic [NRS-1:0] creditReturn_i = '0;
  logic [NRS-1:0] dispValid_o;
  logic [PW-1:0]  dispPayload_o;
  logic           illegalFU_o;
  logic [31:0]    stallCycles_o;
  logic [31:0]    dispatchCount_o;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  logic [FCS-1:0] fu_mem [64];
  logic [PW-1:0]  pl_mem [64];
  int             wr_ptr = 0;
  int             rd_ptr = 0;

  always #5 clock_i = ~clock_i;

  inorder_queue_dispatcher dut (
    .clock_i         (clock_i),
    .reset_i         (reset_i),
    .qEmpty_i        (qEmpty_i),
    .qFuncUnitType_i (qFuncUnitType_i),
    .qPayload_i      (qPayload_i),
    .qReadEnable_o   (qReadEnable_o),
    .flush_i         (flush_i),
    .creditReturn_i  (creditReturn_i),
    .dispValid_o     (dispValid_o),
    .dispPayload_o   (dispPayload_o),
    .illegalFU_o     (illegalFU_o),
    .stallCycles_o   (stallCycles_o),
    .dispatchCount_o (dispatchCount_o)
  );

  // Queue model: head outputs registered on the read strobe.
  assign qEmpty_i = (rd_ptr == wr_ptr);
  always @(posedge clock_i) begin
    if (qReadEnable_o && rd_ptr != wr_ptr) begin
      qFuncUnitType_i <= fu_mem[rd_ptr];
      qPayload_i      <= pl_mem[rd_ptr];
      rd_ptr          <= rd_ptr + 1;
    end
  end

  task automatic tick;
    @(posedge clock_i);
    @(negedge clock_i);
    cycle = cycle + 1;
  endtask

  task automatic do_reset;
    reset_i = 1'b1;
    tick();
    tick();
    reset_i = 1'b0;
  endtask

  task automatic push(input logic [FCS-1:0] fu, input logic [PW-1:0] pl);
    fu_mem[wr_ptr] = fu;
    pl_mem[wr_ptr] = pl;
    wr_ptr = wr_ptr + 1;
  endtask

  function automatic logic [PW-1:0] mk_pl(input int i);
    return {16'(i), 273'd0, 16'h5A00 | 16'(i)};
  endfunction

  task automatic test_reset;
    do_reset();
    for (int n = 0; n < 10; n++) begin
      checks++;
      if (qReadEnable_o !== 1'b0) begin
        errors++;
        $display("FAIL reset_re cycle %0d got %b want 0", n, qReadEnable_o);
      end
      checks++;
      if (dispValid_o !== 4'b0000) begin
        errors++;
        $display("FAIL reset_dv cycle %0d got %b want 0000", n, dispValid_o);
      end
      tick();
    end
    for (int k = 0; k < NRS; k++) begin
      checks++;
      if (dut.credit[k] !== 4'd8) begin
        errors++;
        $display("FAIL reset_credit[%0d] got %0d want 8", k, dut.credit[k]);
      end
    end
    checks++;
    if (dispPayload_o !== '0 || illegalFU_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs payload %h illegal %b want 0 0", dispPayload_o, illegalFU_o);
    end
    checks++;
    if (stallCycles_o !== 32'd0 || dispatchCount_o !== 32'd0) begin
      errors++;
      $display("FAIL reset_counters got %0d %0d want 0 0", stallCycles_o, dispatchCount_o);
    end
  endtask

  task automatic test_single;
    logic [PW-1:0] pl;
    pl = {16'hBEEF, 273'd0, 16'hABCD};
    do_reset();
    push(3'd2, pl);
    for (int n = 1; n <= 5; n++) begin
      tick();
      checks++;
      if (qReadEnable_o !== (n == 1)) begin
        errors++;
        $display("FAIL single_re cycle %0d got %b want %b", n, qReadEnable_o, (n == 1));
      end
      checks++;
      if (dispValid_o !== ((n == 4) ? 4'b0100 : 4'b0000)) begin
        errors++;
        $display("FAIL single_dv cycle %0d got %b", n, dispValid_o);
      end
    end
    checks++;
    if (dispPayload_o !== pl) begin
      errors++;
      $display("FAIL single_payload got %h want %h", dispPayload_o, pl);
    end
    checks++;
    if (dut.credit[2] !== 4'd7) begin
      errors++;
      $display("FAIL single_credit2 got %0d want 7", dut.credit[2]);
    end
  endtask

  task automatic test_back_to_back;
    int got;
    int last;
    do_reset();
    for (int i = 0; i < 9; i++) push(3'd1, mk_pl(i));
    got  = 0;
    last = cycle;
    for (int b = 0; b < 80 && got < 8; b++) begin
      tick();
      if (dispValid_o !== 4'b0000) begin
        checks++;
        if (dispValid_o !== 4'b0010 || dispPayload_o !== mk_pl(got)) begin
          errors++;
          $display("FAIL b2b_dispatch %0d got %b %h want 0010 %h", got, dispValid_o, dispPayload_o, mk_pl(got));
        end
        checks++;
        if (cycle - last != 4) begin
          errors++;
          $display("FAIL b2b_gap %0d got %0d want 4", got, cycle - last);
        end
        last = cycle;
        got++;
      end
    end
    checks++;
    if (got != 8) begin
      errors++;
      $display("FAIL b2b_count got %0d want 8", got);
    end
    for (int n = 0; n < 10; n++) begin
      tick();
      checks++;
      if (dispValid_o !== 4'b0000) begin
        errors++;
        $display("FAIL b2b_stalled_dv cycle %0d got %b want 0000", n, dispValid_o);
      end
    end
    checks++;
    if (dut.credit[1] !== 4'd0) begin
      errors++;
      $display("FAIL b2b_credit1 got %0d want 0", dut.credit[1]);
    end
`ifdef DISPATCH_STATS_EN
    checks++;
    if (stallCycles_o !== 32'd7) begin
      errors++;
      $display("FAIL b2b_stall_mid got %0d want 7", stallCycles_o);
    end
`endif
    creditReturn_i = 4'b0010;
    tick();
    creditReturn_i = 4'b0000;
    checks++;
    if (dispValid_o !== 4'b0000) begin
      errors++;
      $display("FAIL b2b_return_cycle_dv got %b want 0000", dispValid_o);
    end
    tick();
    checks++;
    if (dispValid_o !== 4'b0010 || dispPayload_o !== mk_pl(8)) begin
      errors++;
      $display("FAIL b2b_ninth got %b %h want 0010 %h", dispValid_o, dispPayload_o, mk_pl(8));
    end
`ifdef DISPATCH_STATS_EN
    checks++;
    if (stallCycles_o !== 32'd8 || dispatchCount_o !== 32'd9) begin
      errors++;
      $display("FAIL b2b_stats got %0d %0d want 8 9", stallCycles_o, dispatchCount_o);
    end
`else
    checks++;
    if (stallCycles_o !== 32'd0 || dispatchCount_o !== 32'd0) begin
      errors++;
      $display("FAIL b2b_stats_off got %0d %0d want 0 0", stallCycles_o, dispatchCount_o);
    end
`endif
  endtask

  task automatic test_illegal;
    do_reset();
    push(3'd5, mk_pl(77));
    for (int n = 1; n <= 6; n++) begin
      tick();
      checks++;
      if (illegalFU_o !== (n == 4)) begin
        errors++;
        $display("FAIL illegal_pulse cycle %0d got %b want %b", n, illegalFU_o, (n == 4));
      end
      checks++;
      if (dispValid_o !== 4'b0000) begin
        errors++;
        $display("FAIL illegal_dv cycle %0d got %b want 0000", n, dispValid_o);
      end
    end
    for (int k = 0; k < NRS; k++) begin
      checks++;
      if (dut.credit[k] !== 4'd8) begin
        errors++;
        $display("FAIL illegal_credit[%0d] got %0d want 8", k, dut.credit[k]);
      end
    end
  endtask

  task automatic test_flush;
    int got;
    logic [PW-1:0] pl;
    pl = {16'hF1F1, 273'd0, 16'h0F0F};
    do_reset();
    for (int i = 0; i < 9; i++) push(3'd0, mk_pl(100 + i));
    got = 0;
    for (int b = 0; b < 80 && got < 8; b++) begin
      tick();
      if (dispValid_o !== 4'b0000) got++;
    end
    checks++;
    if (got != 8) begin
      errors++;
      $display("FAIL flush_fill got %0d want 8", got);
    end
    for (int n = 0; n < 5; n++) tick();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    checks++;
    if (dispValid_o !== 4'b0000) begin
      errors++;
      $display("FAIL flush_dv got %b want 0000", dispValid_o);
    end
    creditReturn_i = 4'b0001;
    tick();
    creditReturn_i = 4'b0000;
    for (int n = 0; n < 6; n++) begin
      tick();
      checks++;
      if (dispValid_o !== 4'b0000 || qReadEnable_o !== 1'b0) begin
        errors++;
        $display("FAIL flush_dropped cycle %0d got dv %b re %b want 0000 0", n, dispValid_o, qReadEnable_o);
      end
    end
    checks++;
    if (dut.credit[0] !== 4'd1) begin
      errors++;
      $display("FAIL flush_credit0 got %0d want 1", dut.credit[0]);
    end
    push(3'd0, pl);
    for (int n = 1; n <= 4; n++) tick();
    checks++;
    if (dispValid_o !== 4'b0001 || dispPayload_o !== pl) begin
      errors++;
      $display("FAIL flush_after_pop got %b %h want 0001 %h", dispValid_o, dispPayload_o, pl);
    end
  endtask

  task automatic test_same_cycle;
    int got;
    do_reset();
    for (int i = 0; i < 3; i++) push(3'd3, mk_pl(200 + i));
    got = 0;
    for (int b = 0; b < 40 && got < 3; b++) begin
      tick();
      if (dispValid_o !== 4'b0000) got++;
    end
    checks++;
    if (dut.credit[3] !== 4'd5 || got != 3) begin
      errors++;
      $display("FAIL same_setup got credit %0d dispatches %0d want 5 3", dut.credit[3], got);
    end
    push(3'd3, mk_pl(300));
    tick();
    tick();
    tick();
    creditReturn_i = 4'b1000;
    tick();
    creditReturn_i = 4'b0000;
    checks++;
    if (dispValid_o !== 4'b1000) begin
      errors++;
      $display("FAIL same_dv got %b want 1000", dispValid_o);
    end
    checks++;
    if (dut.credit[3] !== 4'd5) begin
      errors++;
      $display("FAIL same_credit got %0d want 5", dut.credit[3]);
    end
    for (int n = 0; n < 3; n++) begin
      creditReturn_i = 4'b1000;
      tick();
      creditReturn_i = 4'b0000;
    end
    checks++;
    if (dut.credit[3] !== 4'd8) begin
      errors++;
      $display("FAIL refill_credit got %0d want 8", dut.credit[3]);
    end
    creditReturn_i = 4'b1000;
    tick();
    creditReturn_i = 4'b0000;
    checks++;
    if (dut.credit[3] !== 4'd8) begin
      errors++;
      $display("FAIL saturate_credit got %0d want 8", dut.credit[3]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1);
  end

  initial begin
    @(negedge clock_i);
    test_reset();
    test_single();
    test_back_to_back();
    test_illegal();
    test_flush();
    test_same_cycle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
